rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares one synchronous single-port image ROM (index output, feeding a palette lookup) among up to NUM_REQ pixel-fetch requesters.
- Typical requesters: background scan-out, tank sprites, projectile sprites.
- Grants at most one address per vga_clk, forwards it to the ROM and routes the returned index back to the owning requester after the fixed ROM read latency.
- Sits between the per-layer draw logic and the ROM instance; the palette stays downstream of each requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 17, ROM address width.
- DATA_W, 4, ROM data (palette index) width.
- ROM_LAT, 1, ROM read latency in cycles, address to q (1..3).

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester fetch request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant; handshake for requester i completes when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NUM_REQ  one-hot; marks rsp_data as belonging to requester i.
- rsp_data  out  DATA_W  returned palette index.
- rom_address  out  ADDR_W  address to the ROM.
- rom_q  in  DATA_W  ROM data.
- busy  out  1  high while any response is still in flight.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design):
  - RR pointer = 0; tag pipeline cleared.
  - rsp_valid = 0, rsp_data = 0, rom_address = 0, busy = 0, req_ready = 0.
- Grant is combinational from req_valid and the RR pointer:
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - The first valid requester gets req_ready high that cycle.
  - At most one req_ready bit is high per cycle.
- rom_address = req_addr of the granted requester.
  - With no grant, rom_address holds its last registered value (no glitching to 0).
  - Implement as a registered copy that is muxed through only on a grant.
- Pointer update on handshake to i: pointer <= (i+1) mod NUM_REQ. No handshake: pointer unchanged.
- Requester rule: once req_valid is high, req_valid and the address stay stable until ready. The arbiter does not check this. A dropped request with no handshake consumes nothing.
- Tag pipeline: ROM_LAT stages, each holding a one-hot grant vector.
  - Stage 0 captures the grant vector on the handshake cycle.
  - Exactly ROM_LAT cycles after the handshake, rsp_valid = that vector and rsp_data = rom_q, both combinational from the final stage and rom_q.
  - rsp_data = 0 when rsp_valid = 0.
- Throughput: one handshake per cycle, back-to-back, with no bubbles.
- Fairness: under continuous requests from every requester, each is served exactly once every NUM_REQ cycles.
- busy = OR of all tag stages.
- Reset mid-operation: in-flight responses are discarded, with no rsp_valid after reset.
- Simultaneous handshake and response in one cycle are independent and both occur.
- ROM contents are not checked. The ROM address is not range-limited; the requester owns bounds.

Optional Feature:
- Macro: ROM_ARB_BG_PRIORITY_EN.
- Defined:
  - Requester 0 (background scan-out) wins whenever req_valid[0] is high, regardless of the pointer.
  - The pointer arbitrates only among requesters 1..NUM_REQ-1 and updates only on their grants; a grant to requester 0 leaves it unchanged.
- Undefined: pure round-robin over all requesters, as above.

Decomposition:
- Package rom_arb_pkg holds:
  - constants for the default ADDR_W, DATA_W and ROM_LAT;
  - a function rr_pick(valid, pointer) returning the one-hot grant;
  - a typedef for the tag vector.
- One natural sub-module: rom_arb_rr_grant. It is combinational round-robin selection plus the pointer register, and is reusable by other shared-resource arbiters.

Test Plan:
- Reset mid-response: req 0 at addr 0x00010 handshakes; reset_n pulled low during the cycle the response is due -> no rsp_valid, busy=0, outputs 0.
- Single requester: req 2 holds addr 0x12C00 for 3 cycles, ROM returns 0xA -> req_ready[2] high every cycle; rsp_valid=4'b0100 with rsp_data=0xA exactly ROM_LAT cycles after each handshake.
- Full contention: all 4 valid continuously from pointer 0 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_valid sequence identical, delayed ROM_LAT.
- Idle hold: after a grant at addr 0x00100, all valid low for 5 cycles -> rom_address stays 0x00100, rsp_valid=0 after the drain, busy falls.
- Wrap and skip: pointer=3, valid=4'b0011 -> grant 0 then 1; pointer ends at 2.
- With ROM_ARB_BG_PRIORITY_EN: valid=4'b1111 for 6 cycles, then req 0 deasserted -> req 0 granted all 6 cycles; next grants 1,2,3. Repeat without the macro -> 0,1,2,3,0,1.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM port arbiter: default geometry, the
// one-hot tag type carried down the response pipeline, and the
// round-robin pick function used by rom_arb_rr_grant.
package rom_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 17;
  localparam int unsigned DEF_DATA_W  = 4;
  localparam int unsigned DEF_ROM_LAT = 1;
  localparam int unsigned MAX_REQ     = 8;

  // One-hot requester vector, sized for the largest supported arbiter.
  typedef logic [MAX_REQ-1:0] tag_t;

  // First valid requester at or after pointer, wrapping modulo n.
  function automatic tag_t rr_pick(input tag_t valid, input logic [2:0] pointer,
                                   input int unsigned n);
    tag_t       pick;
    logic [2:0] idx;
    pick = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 3'((32'(pointer) + k) % n);
      if (k < n && pick == '0 && valid[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rom_arb_rr_grant.sv
// Round-robin grant: combinational one-hot selection starting at the
// pointer, plus the pointer register that moves past the winner
// whenever the caller reports that the grant was taken.
module rom_arb_rr_grant
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic [2:0] pointer;
  logic [2:0] pointer_next;

  // Select the first valid requester from the pointer onward.
  always_comb begin
    grant = (NUM_REQ)'(rr_pick(tag_t'(valid), pointer, NUM_REQ));
  end

  // Pointer moves to the slot just after the current winner.
  always_comb begin
    pointer_next = pointer;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) pointer_next = (i + 1 == NUM_REQ) ? 3'd0 : 3'(i + 1);
    end
  end

  // Pointer register, updated only when the grant completes a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pointer <= '0;
    else if (advance) pointer <= pointer_next;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous single-port image ROM among NUM_REQ pixel-fetch
// requesters. One address is granted per vga_clk; a one-hot tag follows
// the ROM latency so the returned palette index reaches its owner.
// Optional build macro ROM_ARB_BG_PRIORITY_EN: requester 0 (background
// scan-out) always wins and round-robin covers requesters 1..NUM_REQ-1.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ROM_LAT = DEF_ROM_LAT
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      busy
);

  logic [NUM_REQ-1:0] rr_valid;
  logic [NUM_REQ-1:0] rr_grant;
  logic               rr_advance;
  logic [ADDR_W-1:0]  grant_addr;
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_REQ-1:0] tag_pipe [ROM_LAT];

  rom_arb_rr_grant #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk    (vga_clk),
    .rst_n  (reset_n),
    .valid  (rr_valid),
    .advance(rr_advance),
    .grant  (rr_grant)
  );

  // Final grant; a grant is a handshake because it implies req_valid.
  always_comb begin
`ifdef ROM_ARB_BG_PRIORITY_EN
    // Requester 0 bypasses the ring, so it never moves the pointer.
    rr_valid   = {req_valid[NUM_REQ-1:1], 1'b0};
    rr_advance = (|rr_grant) && !req_valid[0];
    req_ready  = req_valid[0] ? NUM_REQ'(1) : rr_grant;
`else
    rr_valid   = req_valid;
    rr_advance = |rr_grant;
    req_ready  = rr_grant;
`endif
    if (!reset_n) req_ready = '0;
  end

  // Address of the granted requester; rom_address holds when idle.
  always_comb begin
    grant_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
    rom_address = (|req_ready) ? grant_addr : addr_q;
  end

  // Registered copy of the last granted address.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)        addr_q <= '0;
    else if (|req_ready) addr_q <= grant_addr;
  end

  // Tag pipeline matching the ROM read latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < ROM_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= req_ready;
      for (int unsigned s = 1; s < ROM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // Response routing and in-flight indication.
  always_comb begin
    rsp_valid = tag_pipe[ROM_LAT-1];
    rsp_data  = (|rsp_valid) ? rom_q : '0;
    busy      = 1'b0;
    for (int unsigned s = 0; s < ROM_LAT; s++) busy = busy | (|tag_pipe[s]);
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed and table-driven sequences plus
// constrained-random requesters, all checked against a queue-based model.
module tb_rom_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 17;
  localparam int DW  = 4;
  localparam int LAT = 1;
`ifdef ROM_ARB_BG_PRIORITY_EN
  localparam bit BG = 1'b1;
`else
  localparam bit BG = 1'b0;
`endif

  logic            vga_clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data, rom_q;
  logic [AW-1:0]   rom_address;
  logic            busy;
  logic [AW-1:0]   addr [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  rom_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_address(rom_address), .rom_q(rom_q), .busy(busy)
  );

  always_comb begin
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
  end

  // ROM contents: xor-fold of the address nibbles, salted.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]} ^ 4'h5;
  endfunction

  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge vga_clk) begin
    rom_pipe[0] <= rom_f(rom_address);
    for (int s = 1; s < LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_q = rom_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic [N-1:0] vec; logic [AW-1:0] a; } flight_t;
  flight_t     inflight[$];
  int          m_ptr  = 0;
  logic [AW-1:0] m_last = '0;
  int          cyc    = 0;

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    if (BG && v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (BG && i == 0) continue;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge vga_clk) begin
    if (!reset_n) begin
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rom_address", rom_address, 0);
      check("rst_busy", busy, 0);
      inflight.delete();
      m_ptr  = 0;
      m_last = '0;
    end else begin
      int            w;
      logic [N-1:0]  g, ev;
      logic [DW-1:0] ed;
      w  = model_pick(req_valid, m_ptr);
      g  = (w >= 0) ? N'(1 << w) : '0;
      ev = '0;
      ed = '0;
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        ev = inflight[0].vec;
        ed = rom_f(inflight[0].a);
      end
      check("m_ready", req_ready, g);
      check("m_rom_address", rom_address, (w >= 0) ? addr[w] : m_last);
      check("m_rsp_valid", rsp_valid, ev);
      check("m_rsp_data", rsp_data, ed);
      check("m_busy", busy, inflight.size() > 0);
      while (inflight.size() > 0 && inflight[0].due <= cyc) void'(inflight.pop_front());
      if (w >= 0) begin
        inflight.push_back('{due: cyc + LAT, vec: g, a: addr[w]});
        m_last = addr[w];
        if (!(BG && w == 0)) m_ptr = (w + 1) % N;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [N-1:0] v);
    @(posedge vga_clk); #1;
    req_valid = v;
    @(negedge vga_clk);
  endtask

  typedef struct { logic [N-1:0] valid; logic [N-1:0] exp_ready; } vec_t;
  vec_t tbl [9];
  logic [N-1:0] last_ready;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) addr[i] = '0;

`ifdef ROM_ARB_BG_PRIORITY_EN
    tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0001},
            '{4'b1111, 4'b0001}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0001},
            '{4'b1110, 4'b0010}, '{4'b1110, 4'b0100}, '{4'b1110, 4'b1000}};
`else
    tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
            '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010},
            '{4'b1110, 4'b0100}, '{4'b1110, 4'b1000}, '{4'b1110, 4'b0010}};
`endif

    // reset state
    repeat (3) @(negedge vga_clk);
    check("reset_ready", req_ready, 0);
    check("reset_rom_address", rom_address, 0);
    check("reset_busy", busy, 0);
    @(posedge vga_clk); #1 reset_n = 1'b1;

    // reset while a response is due
    addr[0] = 17'h00010;
    drive(4'b0001);
    check("rmid_ready", req_ready, 4'b0001);
    check("rmid_addr", rom_address, 17'h00010);
    @(posedge vga_clk); #1;
    reset_n = 1'b0; req_valid = '0;
    @(negedge vga_clk);
    check("rmid_rsp_valid", rsp_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_rsp_data", rsp_data, 0);
    check("rmid_rom_address", rom_address, 0);
    @(posedge vga_clk); #1 reset_n = 1'b1;

    // full contention from pointer 0, table driven
    for (int i = 0; i < N; i++) addr[i] = AW'(32'h1000 * (i + 1));
    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].valid);
      check($sformatf("tbl%0d_ready", r), req_ready, tbl[r].exp_ready);
      if (r >= LAT) check($sformatf("tbl%0d_rsp", r), rsp_valid, tbl[r-LAT].exp_ready);
    end
    drive('0);
    check("tbl_tail_rsp", rsp_valid, tbl[8].exp_ready);

    // single requester, back to back
    addr[2] = 17'h12C00;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100);
      check("single_ready", req_ready, 4'b0100);
      check("single_addr", rom_address, 17'h12C00);
      if (k >= 1) begin
        check("single_rsp", rsp_valid, 4'b0100);
        check("single_data", rsp_data, 4'hA);
      end
    end
    drive('0);
    check("single_last_rsp", rsp_valid, 4'b0100);
    check("single_last_data", rsp_data, 4'hA);

    // idle hold of rom_address
    addr[1] = 17'h00100;
    drive(4'b0010);
    check("idle_ready", req_ready, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      drive('0);
      check("idle_addr", rom_address, 17'h00100);
      if (k == 0) check("idle_busy_on", busy, 1);
      else begin
        check("idle_rsp", rsp_valid, 0);
        check("idle_busy_off", busy, 0);
      end
    end

    // wrap and skip: pointer to 3, then 0 and 1, pointer ends at 2
    drive(4'b0100);
    check("wrap_setup", req_ready, 4'b0100);
    drive(4'b0011);
    check("wrap_g0", req_ready, 4'b0001);
    drive(4'b0010);
    check("wrap_g1", req_ready, 4'b0010);
    drive(4'b1110);
    check("wrap_ptr2", req_ready, 4'b0100);
    drive('0);

    // randomized requesters obeying the hold-until-ready rule
    last_ready = '0;
    for (int n = 0; n < 400; n++) begin
      @(posedge vga_clk); #1;
      if (n == 200) begin
        reset_n = 1'b0; req_valid = '0;
      end else begin
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && last_ready[i]) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            addr[i]      = AW'($urandom);
          end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            addr[i]      = AW'($urandom);
          end
        end
      end
      @(negedge vga_clk);
      last_ready = req_ready;
    end
    drive('0);
    drive('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
